// File: rtl/hilo_unit.sv
// HI/LO register unit: single-cycle multiplies, local handling of trivial divides,
// magnitude issue to an external iterative divider with MIPS sign fix-up on return.
module hilo_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        op_ready,
  output logic        mf_valid,
  output logic [31:0] mf_result,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_valid_in,
  output logic [31:0] div_src_a,
  output logic [31:0] div_src_b,
  input  logic        div_valid_out,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo
);

  localparam logic S_IDLE     = 1'b0;
  localparam logic S_DIV_WAIT = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic        r_state;
  logic        r_sq;
  logic        r_sr;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_mf_valid;
  logic [31:0] r_mf_result;
  logic        r_div_valid_in;
  logic [31:0] r_div_src_a;
  logic [31:0] r_div_src_b;

  logic        w_accept;
  logic        w_signed_div;
  logic [31:0] w_ma;
  logic [31:0] w_mb;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_done;

  assign op_ready     = (r_state == S_IDLE);
  assign w_accept     = op_valid && op_ready;
  assign w_signed_div = (op == OP_DIV);

  // Sign-extending to 64 bits first makes the truncated unsigned product the signed product.
  assign w_prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign w_prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  assign w_ma = (w_signed_div && rs_val[31]) ? -rs_val : rs_val;
  assign w_mb = (w_signed_div && rt_val[31]) ? -rt_val : rt_val;

  // The divider's output in the issue cycle is stale, so completion is only taken afterwards.
  assign w_done = (r_state == S_DIV_WAIT) && div_valid_out && !r_div_valid_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_sq           <= 1'b0;
      r_sr           <= 1'b0;
      r_hi           <= '0;
      r_lo           <= '0;
      r_mf_valid     <= 1'b0;
      r_mf_result    <= '0;
      r_div_valid_in <= 1'b0;
      r_div_src_a    <= '0;
      r_div_src_b    <= '0;
    end else begin
      r_mf_valid     <= 1'b0;
      r_div_valid_in <= 1'b0;
      if (w_accept) begin
        case (op)
          OP_MULT:  {r_hi, r_lo} <= w_prod_s;
          OP_MULTU: {r_hi, r_lo} <= w_prod_u;
          OP_DIV, OP_DIVU: begin
            if (rt_val == '0) begin
              r_lo <= '1;
              r_hi <= rs_val;
            end else if (w_ma < w_mb) begin
              r_lo <= '0;
              r_hi <= rs_val;
            end else begin
              r_div_src_a    <= w_ma;
              r_div_src_b    <= w_mb;
              r_div_valid_in <= 1'b1;
              r_sq           <= w_signed_div && (rs_val[31] ^ rt_val[31]);
              r_sr           <= w_signed_div && rs_val[31];
              r_state        <= S_DIV_WAIT;
            end
          end
          OP_MTHI: r_hi <= rs_val;
          OP_MTLO: r_lo <= rs_val;
          OP_MFHI: begin
            r_mf_result <= r_hi;
            r_mf_valid  <= 1'b1;
          end
          OP_MFLO: begin
            r_mf_result <= r_lo;
            r_mf_valid  <= 1'b1;
          end
          default: ;
        endcase
      end
      if (w_done) begin
        r_lo    <= r_sq ? -div_hi : div_hi;
        r_hi    <= r_sr ? -div_lo : div_lo;
        r_state <= S_IDLE;
      end
    end
  end

  assign hi           = r_hi;
  assign lo           = r_lo;
  assign mf_valid     = r_mf_valid;
  assign mf_result    = r_mf_result;
  assign div_valid_in = r_div_valid_in;
  assign div_src_a    = r_div_src_a;
  assign div_src_b    = r_div_src_b;

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit with a behavioural iterative divider attached.
module tb_hilo_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        op_valid;
  logic [3:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        op_ready;
  logic        mf_valid;
  logic [31:0] mf_result;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_valid_in;
  logic [31:0] div_src_a;
  logic [31:0] div_src_b;
  logic        div_valid_out;
  logic [31:0] div_hi;
  logic [31:0] div_lo;

  hilo_unit dut (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .op_ready(op_ready),
    .mf_valid(mf_valid), .mf_result(mf_result), .hi(hi), .lo(lo),
    .div_valid_in(div_valid_in), .div_src_a(div_src_a), .div_src_b(div_src_b),
    .div_valid_out(div_valid_out), .div_hi(div_hi), .div_lo(div_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 local/simple, 1 move-from, 2 issued divide
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf;
    logic [31:0] sa;
    logic [31:0] sb;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  bit          mon_busy = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Divider model: no reset, variable latency, divisor reread at completion,
  // and an occasional stale completion pulse in the issue cycle.
  bit          dv_busy = 0;
  int          dv_cnt = 0;
  logic [31:0] dv_a = '0;
  initial begin
    div_valid_out = 1'b0;
    div_hi = '0;
    div_lo = '0;
    forever begin
      @(negedge clk);
      div_valid_out = 1'b0;
      if (div_valid_in === 1'b1) begin
        dv_busy = 1;
        dv_cnt  = $urandom_range(0, 6);
        dv_a    = div_src_a;
        if ($urandom_range(0, 1) == 1) begin
          div_valid_out = 1'b1;
          div_hi = $urandom;
          div_lo = $urandom;
        end
      end else if (dv_busy) begin
        if (dv_cnt == 0) begin
          div_valid_out = 1'b1;
          div_hi  = dv_a / div_src_b;
          div_lo  = dv_a % div_src_b;
          dv_busy = 0;
        end else begin
          dv_cnt--;
        end
      end
    end
  end

  // Reference model: MIPS semantics from plain 64-bit arithmetic.
  function automatic exp_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb, q, r;
    logic [63:0] p;
    logic [31:0] ma, mb;
    e.kind = 0; e.mf = '0; e.sa = '0; e.sb = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      4'd1: begin p = 64'(sa * sb); {m_hi, m_lo} = p; end
      4'd2: begin p = 64'(a) * 64'(b); {m_hi, m_lo} = p; end
      4'd3, 4'd4: begin
        if (o == 4'd3) begin
          ma = 32'(sa < 0 ? -sa : sa);
          mb = 32'(sb < 0 ? -sb : sb);
        end else begin
          ma = a; mb = b;
        end
        if (b == 0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = a;
        end else begin
          if (o == 4'd3) begin q = sa / sb; r = sa % sb; end
          else begin q = longint'(a) / longint'(b); r = longint'(a) % longint'(b); end
          m_lo = 32'(q); m_hi = 32'(r);
          if (ma >= mb) begin e.kind = 2; e.sa = ma; e.sb = mb; end
        end
      end
      4'd5: m_hi = a;
      4'd6: m_lo = a;
      4'd7: begin e.kind = 1; e.mf = m_hi; end
      4'd8: begin e.kind = 1; e.mf = m_lo; end
      default: ;
    endcase
    e.hi = m_hi;
    e.lo = m_lo;
    return e;
  endfunction

  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input bit push);
    int k;
    @(negedge clk);
    op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
    for (k = 0; k < 300 && op_ready !== 1'b1; k++) @(negedge clk);
    if (op_ready !== 1'b1) begin
      errors++; checks++;
      $display("FAIL accept_timeout: op %0d never accepted", o);
    end else if (push) begin
      sb_q.push_back(model(o, a, b));
    end
    @(posedge clk);
    #1 op_valid = 1'b0;
  endtask

  // Monitor: pops one expectation per accepted operation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        mon_busy = 1;
        e = sb_q.pop_front();
        if (e.kind == 2) begin
          chk("div_valid_in", {31'd0, div_valid_in}, 32'd1);
          chk("div_src_a", div_src_a, e.sa);
          chk("div_src_b", div_src_b, e.sb);
          chk("op_ready_stall", {31'd0, op_ready}, 32'd0);
          for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (op_ready === 1'b1) break;
          end
          chk("div_done_ready", {31'd0, op_ready}, 32'd1);
        end else begin
          chk("no_div_issue", {31'd0, div_valid_in}, 32'd0);
          chk("mf_valid", {31'd0, mf_valid}, (e.kind == 1) ? 32'd1 : 32'd0);
          if (e.kind == 1) chk("mf_result", mf_result, e.mf);
        end
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        mon_busy = 0;
      end
    end
  end

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    reset_n = 1'b0; op_valid = 1'b0; op = '0; rs_val = '0; rt_val = '0;
    #12;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_mf_result", mf_result, 32'd0);
    chk("rst_mf_valid", {31'd0, mf_valid}, 32'd0);
    chk("rst_div_valid_in", {31'd0, div_valid_in}, 32'd0);
    chk("rst_div_src_a", div_src_a, 32'd0);
    chk("rst_div_src_b", div_src_b, 32'd0);
    chk("rst_op_ready", {31'd0, op_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    do_op(4'd1, 32'hFFFF_FFFD, 32'd5, 1);
    do_op(4'd2, 32'hFFFF_FFFD, 32'd5, 1);
    do_op(4'd4, 32'd100, 32'd7, 1);
    do_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1);
    do_op(4'd3, 32'd7, 32'hFFFF_FFFE, 1);
    do_op(4'd3, 32'd5, 32'd0, 1);
    do_op(4'd4, 32'd3, 32'd10, 1);
    do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    do_op(4'd5, 32'h1234, 32'd0, 1);
    do_op(4'd4, 32'd100, 32'd7, 1);
    do_op(4'd7, 32'd0, 32'd0, 1);

    // Abandon an in-flight divide with reset; the late completion must be ignored.
    for (int k = 0; k < 400 && (sb_q.size() != 0 || mon_busy); k++) @(negedge clk);
    repeat (10) @(negedge clk);
    do_op(4'd4, 32'd100, 32'd7, 0);
    @(posedge clk);
    #3;
    chk("pre_reset_stall", {31'd0, op_ready}, 32'd0);
    reset_n = 1'b0;
    m_hi = '0; m_lo = '0;
    #1;
    chk("async_rst_ready", {31'd0, op_ready}, 32'd1);
    chk("async_rst_hi", hi, 32'd0);
    chk("async_rst_lo", lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("late_done_hi", hi, 32'd0);
    chk("late_done_lo", lo, 32'd0);
    do_op(4'd8, 32'd0, 32'd0, 1);

    for (int n = 0; n < 200; n++) begin
      ro = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) ro = ($urandom_range(0, 1) == 0) ? 4'd3 : 4'd4;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = -32'($urandom_range(1, 20));
        3: ra = 32'($urandom_range(0, 50));
        default: ;
      endcase
      do_op(ro, ra, rb, 1);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    for (int k = 0; k < 400 && (sb_q.size() != 0 || mon_busy); k++) @(negedge clk);
    if (sb_q.size() != 0 || mon_busy) begin
      errors++; checks++;
      $display("FAIL drain: %0d expectations left", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

HI/LO register unit sitting directly upstream of the iterative unsigned divider and owning the architectural HI/LO registers. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from the execute stage. Performs multiplies in one cycle. Performs divide-by-zero and small-dividend cases locally. Sends all other divides to the divider as magnitude operands, then applies MIPS sign correction on return and stalls issue while a divide is in flight.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- op_valid  in  1  operation presented this cycle
- op  in  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9–15 treated as NOP
- rs_val  in  32  operand A / dividend / MT source
- rt_val  in  32  operand B / divisor
- op_ready  out  1  high when state is IDLE (combinational from state)
- mf_valid  out  1  one-cycle pulse carrying MFHI/MFLO data
- mf_result  out  32  HI or LO value read
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- div_valid_in  out  1  one-cycle start pulse to the divider
- div_src_a  out  32  dividend magnitude to the divider
- div_src_b  out  32  divisor magnitude to the divider
- div_valid_out  in  1  divider completion pulse
- div_hi  in  32  divider quotient
- div_lo  in  32  divider remainder

## Operation
- States: IDLE and DIV_WAIT.
- An operation is accepted on a rising edge where op_valid=1 and op_ready=1. In DIV_WAIT, op_ready=0 and op_valid is ignored; upstream holds the operation.
- MULT: {hi,lo} <= signed 64-bit rs_val×rt_val. MULTU uses the unsigned product. HI/LO are updated at the accept edge. State stays IDLE.
- MTHI: hi <= rs_val. MTLO: lo <= rs_val.
- MFHI/MFLO: at the accept edge, mf_result <= hi (or lo) and mf_valid <= 1 for exactly one cycle. The value read is the one held before the edge, so an MTHI accepted at cycle n is visible to an MFHI accepted at cycle n+1.
- DIV/DIVU setup: ma = |rs_val| and mb = |rt_val| for DIV; ma = rs_val and mb = rt_val for DIVU. Record sq = rs[31]^rt[31] and sr = rs[31] (both 0 for DIVU).
  - rt_val == 0: lo <= 32'hFFFF_FFFF and hi <= rs_val. Stay IDLE.
  - ma < mb (unsigned compare): lo <= 0 and hi <= rs_val. Stay IDLE. The divider's shift alignment is invalid for this case, so it is never issued.
  - Otherwise: div_src_a <= ma, div_src_b <= mb, div_valid_in <= 1 for one cycle. Latch sq and sr. Go to DIV_WAIT.
- div_src_a and div_src_b are held stable from issue until the divider completes. The divider rereads the divisor every iteration.
- DIV_WAIT: div_valid_out is ignored in the cycle div_valid_in is high (the divider's stale output). On a later div_valid_out=1:
  - lo <= sq ? -div_hi : div_hi (quotient).
  - hi <= sr ? -div_lo : div_lo (remainder).
  - Go to IDLE.
- Arithmetic is modulo 2^32. DIV 0x8000_0000 / 0xFFFF_FFFF gives lo = 0x8000_0000 and hi = 0.
- Reset: asynchronous and immediate.
  - State = IDLE; hi = lo = 0; mf_result = 0; mf_valid = 0; div_valid_in = 0; div_src_a = div_src_b = 0; op_ready = 1.
  - A divide in flight is abandoned. Because the divider has no reset, its later div_valid_out is ignored in IDLE.
- In IDLE, div_valid_out is always ignored.

## Timing
- MULT/MULTU/MT*: result visible on hi/lo one cycle after accept. No stall.
- MF*: mf_valid and mf_result are registered one cycle after accept.
- Local DIV results (zero divisor or small dividend) are visible one cycle after accept.
- Issued DIV:
  - div_valid_in is high in cycle n+1 (accept at edge n).
  - HI/LO update at the edge where div_valid_out is sampled high.
  - op_ready returns high in the cycle after that edge.
  - A new op can be accepted at the next edge.
- Back-to-back DIVs: the second is accepted no earlier than the cycle after the first completes.

## Test plan
- MULT rs=0xFFFF_FFFD (−3), rt=5 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFF1 one cycle later. MULTU with the same operands -> hi=0x0000_0004, lo=0xFFFF_FFF1.
- DIVU 100/7 with the real divider attached:
  - div_valid_in pulses once with src_a=100, src_b=7.
  - op_ready stays low until completion.
  - Result lo=14, hi=2.
- DIV 0xFFFF_FFF9 (−7) / 2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIV 7 / 0xFFFF_FFFE -> lo=0xFFFF_FFFD, hi=1.
- DIV 5/0 -> lo=0xFFFF_FFFF, hi=5 with no div_valid_in. DIVU 3/10 -> lo=0, hi=3 with no div_valid_in. Both complete in one cycle.
- MTHI 0x1234, then DIVU 100/7 with MFHI held on op_valid during the wait:
  - MFHI is not accepted until op_ready rises.
  - mf_result then equals 2.
- Start DIVU 100/7, assert reset_n=0 mid-wait, release, then MFLO:
  - mf_result=0.
  - The late div_valid_out does not modify lo/hi.
